cell_pos_writeback: RTL

CELL_POS_WRITEBACK -- requirements
Module: cell_pos_writeback

---
 rtl/cell_pos_writeback_pkg.sv | 22 ++
 rtl/cell_pos_writeback_if.sv | 39 +++
 rtl/cell_pos_writeback.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cell_pos_writeback_pkg.sv
// Shared constants and types for the cell position write-back path.
// The width/depth defaults match the constants used by the cell memories.
package cell_pos_writeback_pkg;

    localparam int COORD_WIDTH      = 32;
    localparam int DEF_DATA_WIDTH   = 3 * COORD_WIDTH;
    localparam int DEF_PARTICLE_NUM = 220;
    localparam int DEF_ADDR_WIDTH   = 8;

    // One packed particle position as stored in a cell memory word.
    typedef struct packed {
        logic [COORD_WIDTH-1:0] posz;
        logic [COORD_WIDTH-1:0] posy;
        logic [COORD_WIDTH-1:0] posx;
    } pos_t;

    // Clamp a requested particle count to the memory depth.
    function automatic int unsigned clamp_count(input int unsigned req, input int unsigned depth);
        return (req > depth) ? depth : req;
    endfunction

endpackage

// File: rtl/cell_pos_writeback_if.sv
// Upstream position stream plus the cell memory write port.
// master: the writer (accepts the stream, drives the memory port).
// slave:  the environment (sources the stream, observes the memory port).
interface cell_pos_writeback_if
    import cell_pos_writeback_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_wren;
    logic                  ram_rden;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output ram_address,
        output ram_data,
        output ram_wren,
        output ram_rden
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  ram_address,
        input  ram_data,
        input  ram_wren,
        input  ram_rden
    );

endinterface

// File: rtl/cell_pos_writeback.sv
// Writes one pass of updated particle positions into a cell memory:
// first the n streamed positions at addresses 0..n-1, then zero words up
// to the last memory address, then a one-cycle done pulse.
module cell_pos_writeback
    import cell_pos_writeback_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int PARTICLE_NUM = DEF_PARTICLE_NUM,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_particles,
    cell_pos_writeback_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   wr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counters carry one extra bit so that "n == PARTICLE_NUM" is representable
    // even when the memory depth is a full power of two.
    localparam logic [ADDR_WIDTH:0] PN_CNT    = (ADDR_WIDTH+1)'(PARTICLE_NUM);
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   n_q, n_d;
    logic [ADDR_WIDTH:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]   wr_count_q, wr_count_d;
    logic                  in_ready_q, in_ready_d;
    logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                  ram_wren_q, ram_wren_d;
    logic                  ram_rden_q;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic [ADDR_WIDTH:0]   n_clamped;
    logic [ADDR_WIDTH:0]   count_inc;

    assign accept    = bus.in_valid && in_ready_q;
    assign n_clamped = (num_particles > PN_CNT) ? PN_CNT : num_particles;
    assign count_inc = wr_count_q + CNT_ONE;

    // State register: synchronous active-low reset abandons any pass in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output logic for the write-back pass.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d       = state_q;
        n_d           = n_q;
        addr_d        = addr_q;
        wr_count_d    = wr_count_q;
        in_ready_d    = 1'b0;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = 1'b0;
        done_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_d        = n_clamped;
                    addr_d     = '0;
                    wr_count_d = '0;
                    if (n_clamped != '0) begin
                        state_d    = WRITE;
                        in_ready_d = 1'b1;
                    end else begin
                        state_d    = FILL;
                    end
                end
            end

            WRITE: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    ram_wren_d    = 1'b1;
                    ram_address_d = addr_q[ADDR_WIDTH-1:0];
                    ram_data_d    = bus.in_data;
                    addr_d        = addr_q + CNT_ONE;
                    wr_count_d    = count_inc;
                    if (count_inc == n_q) begin
                        in_ready_d = 1'b0;
                        if (n_q < PN_CNT) begin
                            state_d = FILL;
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            FILL: begin
                ram_wren_d    = 1'b1;
                ram_address_d = addr_q[ADDR_WIDTH-1:0];
                ram_data_d    = '0;
                // The counter parks on the last address instead of wrapping.
                if (addr_q >= LAST_ADDR) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    addr_d  = addr_q + CNT_ONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Datapath and output registers; every output is driven from a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q           <= '0;
            addr_q        <= '0;
            wr_count_q    <= '0;
            in_ready_q    <= 1'b0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            ram_rden_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            n_q           <= n_d;
            addr_q        <= addr_d;
            wr_count_q    <= wr_count_d;
            in_ready_q    <= in_ready_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            ram_rden_q    <= 1'b0;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.ram_address = ram_address_q;
    assign bus.ram_data    = ram_data_q;
    assign bus.ram_wren    = ram_wren_q;
    assign bus.ram_rden    = ram_rden_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign wr_count        = wr_count_q;

endmodule
